cpu_mem_arbiter: RTL
====================

Name: cpu_mem_arbiter

Overview:
- Shares one single-ported memory between the CPU's instruction-fetch port (I) and its load/store port (D).
- Sits between the cpu fetch/LDR datapath and the memory.
- Arbitrates with a starvation guard, sequences each access through a small FSM and aborts accesses the memory never acknowledges.
- Each requester sees a simple req/ack handshake.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_STARVE, 4, consecutive D grants made while I is pending before I is forced to win.
- TIMEOUT, 16, BUSY cycles without mem_ack before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- i_req  in  1  fetch request; held until i_ack.
- i_addr  in  AW  fetch address; stable while i_req is high.
- i_ack  out  1  one-cycle completion pulse.
- i_rdata  out  DW  fetch data; valid with i_ack, held until the next i_ack.
- i_err  out  1  timeout flag; valid with i_ack.
- d_req  in  1  load/store request; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_ack  out  1  one-cycle completion pulse.
- d_rdata  out  DW  load data; valid with d_ack, held until the next d_ack.
- d_err  out  1  timeout flag; valid with d_ack.
- mem_req  out  1  memory request; held until mem_ack or abort.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid when mem_ack is high.
- mem_ack  in  1  memory completion; one cycle.
- owner  out  2  debug: 00 none, 01 I, 10 D.

Behaviour:
- Reset (async, resetn=0): FSM to IDLE; all outputs 0 (acks, errs, mem_req, mem_we, mem_addr, mem_wdata, i_rdata, d_rdata, owner); starve_cnt=0, wait_cnt=0. Asserting reset mid-access drops mem_req immediately, and no ack is issued for the aborted access.
- FSM states: IDLE, BUSY, DONE. All outputs are registered.
- IDLE, neither req high: stay in IDLE.
- IDLE, a req high: choose a winner, latch its addr/we/wdata onto the mem_* outputs (I forces mem_we=0 and mem_wdata=0), set mem_req=1, set owner, clear wait_cnt, go to BUSY.
- Arbitration when both req high: D wins unless starve_cnt==MAX_STARVE, in which case I wins.
- starve_cnt update at each grant: if D is granted while i_req is high, increment (saturating at MAX_STARVE). If I is granted, clear to 0. If D is granted with i_req low, hold.
- BUSY, mem_ack=1: set mem_req=0. Pulse the owner's ack next cycle; for a load or fetch, capture mem_rdata into the owner's rdata. err=0. Go to DONE.
- BUSY, mem_ack=0: wait_cnt++.
  - If TIMEOUT!=0 and wait_cnt reaches TIMEOUT-1 without mem_ack, abort: mem_req=0; owner's ack=1 and err=1; rdata unchanged; go to DONE.
  - The first cycle after abort never samples mem_ack.
- DONE (exactly one cycle): the owner's ack (and err, if set) is high. Requests are ignored. Next state is IDLE, with ack, err and owner cleared.
- A late mem_ack arriving in DONE or IDLE is ignored.
- Latency with a zero-wait memory (mem_ack in the first BUSY cycle): req sampled at edge 0, mem_req high cycle 1, ack high cycle 2.
- Minimum issue interval is 3 cycles; the same requester may keep req high to present a new access in the cycle after its ack.
- A requester dropping req while granted is illegal; the arbiter completes the access regardless.
- Only one ack can be high in any cycle.
- mem_* outputs are stable for the whole of BUSY.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100, mem_ack in the first BUSY cycle with mem_rdata=0xE3A01005 -> mem_req high cycle 1 with mem_addr=0x100 and mem_we=0; i_ack=1 cycle 2 with i_rdata=0xE3A01005 and i_err=0; owner 01 in cycles 1-2.
- Store: d_req=1, d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, mem_ack after 3 wait cycles -> mem_we=1 and mem_wdata=0xDEADBEEF held for 4 BUSY cycles; d_ack exactly one cycle, d_err=0.
- Contention: i_req and d_req both high continuously, MAX_STARVE=4 -> grant order D,D,D,D,I,D,D,D,D,I; i_ack and d_ack never high in the same cycle.
- Timeout: TIMEOUT=16, d_req=1, mem_ack never asserted -> mem_req high for exactly 16 cycles, then d_ack=1 and d_err=1 for one cycle; d_rdata unchanged. A mem_ack injected 2 cycles later produces no ack.
- Reset mid-access: resetn driven low during BUSY -> mem_req, owner and acks 0 immediately, without waiting for a clock edge. After release with i_req=1, a normal fetch completes with starve_cnt=0.
- Back-to-back loads: d_req held high with a new d_addr presented each cycle after d_ack, zero-wait memory -> d_ack every 3rd cycle and addresses issued in order.

Source files
------------

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: shares one single-ported memory between the CPU instruction
// fetch port (I) and its load/store port (D). D normally wins contention, but a
// starvation counter forces I through after MAX_STARVE consecutive D grants made
// while I was waiting. Every access runs IDLE -> BUSY -> DONE, so each requester
// sees one registered ack pulse. An access the memory never acknowledges is
// aborted after TIMEOUT busy cycles and completes with err set.
module cpu_mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MAX_STARVE = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic          clk,
    input  logic          resetn,
    // instruction fetch port
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    output logic          i_err,
    // load/store port
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    // memory port
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    // debug
    output logic [1:0]    owner
);

    localparam int SW = (MAX_STARVE > 0) ? $clog2(MAX_STARVE + 1) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);
    // Last busy cycle count at which a missing mem_ack turns into an abort.
    localparam logic [WW-1:0] WAIT_LAST  = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_I    = 2'b01;
    localparam logic [1:0] OWN_D    = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] starve_cnt, starve_nxt;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic          grant_i;

    logic          mem_req_nxt, mem_we_nxt;
    logic [AW-1:0] mem_addr_nxt;
    logic [DW-1:0] mem_wdata_nxt;
    logic          i_ack_nxt, d_ack_nxt, i_err_nxt, d_err_nxt;
    logic [DW-1:0] i_rdata_nxt, d_rdata_nxt;
    logic [1:0]    owner_nxt;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // values from before the edge, independent of block evaluation order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next state, arbitration and next values of every registered output.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_nxt     = state;
        starve_nxt    = starve_cnt;
        wait_nxt      = wait_cnt;
        grant_i       = 1'b0;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        owner_nxt     = owner;
        i_ack_nxt     = 1'b0;
        d_ack_nxt     = 1'b0;
        i_err_nxt     = 1'b0;
        d_err_nxt     = 1'b0;
        i_rdata_nxt   = i_rdata;
        d_rdata_nxt   = d_rdata;

        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    // D has priority unless I has already been passed over
                    // MAX_STARVE times in a row.
                    grant_i = i_req && (!d_req || (starve_cnt == STARVE_MAX));
                    if (grant_i) begin
                        mem_we_nxt    = 1'b0;
                        mem_addr_nxt  = i_addr;
                        mem_wdata_nxt = '0;
                        owner_nxt     = OWN_I;
                        starve_nxt    = '0;
                    end else begin
                        mem_we_nxt    = d_we;
                        mem_addr_nxt  = d_addr;
                        mem_wdata_nxt = d_wdata;
                        owner_nxt     = OWN_D;
                        if (i_req && (starve_cnt != STARVE_MAX))
                            starve_nxt = starve_cnt + SW'(1);
                    end
                    mem_req_nxt = 1'b1;
                    wait_nxt    = '0;
                    state_nxt   = BUSY;
                end
            end

            BUSY: begin
                if (mem_ack) begin
                    mem_req_nxt = 1'b0;
                    if (owner == OWN_I) begin
                        i_ack_nxt   = 1'b1;
                        i_rdata_nxt = mem_rdata;
                    end else begin
                        d_ack_nxt = 1'b1;
                        if (!mem_we) d_rdata_nxt = mem_rdata;
                    end
                    state_nxt = DONE;
                end else if ((TIMEOUT != 0) && (wait_cnt == WAIT_LAST)) begin
                    // Memory never answered: complete the access with err and
                    // leave the requester's read data untouched.
                    mem_req_nxt = 1'b0;
                    if (owner == OWN_I) begin
                        i_ack_nxt = 1'b1;
                        i_err_nxt = 1'b1;
                    end else begin
                        d_ack_nxt = 1'b1;
                        d_err_nxt = 1'b1;
                    end
                    state_nxt = DONE;
                end else begin
                    wait_nxt = wait_cnt + WW'(1);
                end
            end

            DONE: begin
                // Single ack cycle; requests and stray mem_ack are ignored here.
                owner_nxt = OWN_NONE;
                state_nxt = IDLE;
            end

            default: begin
                owner_nxt   = OWN_NONE;
                mem_req_nxt = 1'b0;
                state_nxt   = IDLE;
            end
        endcase
    end

    // Counters and registered outputs; reset clears every one of them so an
    // access interrupted by reset leaves no request or ack behind.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt <= '0;
            wait_cnt   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            owner      <= OWN_NONE;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_err      <= 1'b0;
            d_err      <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            starve_cnt <= starve_nxt;
            wait_cnt   <= wait_nxt;
            mem_req    <= mem_req_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            owner      <= owner_nxt;
            i_ack      <= i_ack_nxt;
            d_ack      <= d_ack_nxt;
            i_err      <= i_err_nxt;
            d_err      <= d_err_nxt;
            i_rdata    <= i_rdata_nxt;
            d_rdata    <= d_rdata_nxt;
        end
    end

endmodule
